connect4_game_controller: RTL

Sequencing controller for the Connect4 game. It owns the game FSM, the per-column fill heights, the move counter and the current player. It accepts column requests from the input front end and issues placement commands to the board store. It consumes win-check results and drives the 2-bit `state` and `game_status` buses read by the LED status display.

---
 rtl/connect4_pkg.sv | 46 ++++
 rtl/column_height_tracker.sv | 41 ++++
 rtl/connect4_game_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/connect4_pkg.sv
// Shared encodings and constants for the Connect4 game controller.
// Holds the state/status bus codes, internal FSM states and board sizes.
package connect4_pkg;

    localparam int NUM_COLS  = 7;
    localparam int NUM_ROWS  = 6;
    localparam int MAX_MOVES = 42;

    // Codes driven onto the external state bus
    typedef enum logic [1:0] {
        GAME_INIT = 2'b00,
        P1_TURN   = 2'b01,
        P2_TURN   = 2'b10,
        END_GAME  = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        STILL_PLAYING = 2'b00,
        P1_WINS       = 2'b01,
        P2_WINS       = 2'b10,
        TIE           = 2'b11
    } game_status_e;

    // Internal controller states
    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_TURN  = 2'b01,
        S_CHECK = 2'b10,
        S_END   = 2'b11
    } fsm_e;

    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

    // TURN and CHECK both display whose turn it is
    function automatic game_state_e state_code(fsm_e f, logic p);
        game_state_e s;
        unique case (f)
            S_INIT:  s = GAME_INIT;
            S_END:   s = END_GAME;
            default: s = p ? P2_TURN : P1_TURN;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/column_height_tracker.sv
// Per-column fill heights for the Connect4 board.
// Ports: clear/inc/inc_col update heights; rd_col selects height/full outputs.
module column_height_tracker
    import connect4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       inc,
    input  logic [2:0] inc_col,
    input  logic [2:0] rd_col,
    output logic [2:0] height,
    output logic       full
);

    logic [2:0] heights [NUM_COLS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COLS; i++) heights[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_COLS; i++) heights[i] <= '0;
        end else if (inc) begin
            for (int i = 0; i < NUM_COLS; i++)
                if (inc_col == 3'(i)) heights[i] <= heights[i] + 3'd1;
        end
    end

    // Out-of-range columns read as full so they can never be placed
    always_comb begin
        height = '0;
        full   = 1'b1;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (rd_col == 3'(i)) begin
                height = heights[i];
                full   = (heights[i] >= 3'(NUM_ROWS));
            end
        end
    end

endmodule

// File: rtl/connect4_game_controller.sv
// Connect4 sequencing controller: game FSM, move counter, current player.
// Ports: start/move_req/move_col/win_* in; state, game_status, place_*,
// move_ack/move_reject, move_count out. Optional MOVE_TIMEOUT_EN turn timer.
module connect4_game_controller
    import connect4_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       move_req,
    input  logic [2:0] move_col,
    input  logic       win_valid,
    input  logic       win_found,
    output logic [1:0] state,
    output logic [1:0] game_status,
    output logic       place_valid,
    output logic [2:0] place_col,
    output logic [2:0] place_row,
    output logic       place_player,
    output logic       move_ack,
    output logic       move_reject,
    output logic [5:0] move_count
);

    fsm_e         fsm_q, fsm_d;
    logic         player_q, player_d;
    logic [5:0]   count_d;
    game_status_e status_q, status_d;
    logic         pv_d, ack_d, rej_d, pp_d;
    logic [2:0]   pc_d, pr_d;
    logic         ht_clear, ht_inc;
    logic [2:0]   col_height;
    logic         col_full;
    logic         legal;

    column_height_tracker u_heights (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (ht_clear),
        .inc     (ht_inc),
        .inc_col (move_col),
        .rd_col  (move_col),
        .height  (col_height),
        .full    (col_full)
    );

    assign legal = (move_col <= 3'(NUM_COLS - 1)) && !col_full;

`ifdef MOVE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] timer_q, timer_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timer_q <= '0;
        else        timer_q <= timer_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        fsm_d    = fsm_q;
        player_d = player_q;
        count_d  = move_count;
        status_d = status_q;
        pv_d     = 1'b0;
        ack_d    = 1'b0;
        rej_d    = 1'b0;
        pc_d     = '0;
        pr_d     = '0;
        pp_d     = 1'b0;
        ht_clear = 1'b0;
        ht_inc   = 1'b0;
`ifdef MOVE_TIMEOUT_EN
        timer_d  = '0;
`endif
        unique case (fsm_q)
            S_INIT: begin
                if (start) begin
                    fsm_d    = S_TURN;
                    player_d = PLAYER_1;
                    count_d  = '0;
                    status_d = STILL_PLAYING;
                    ht_clear = 1'b1;
                end
            end
            S_TURN: begin
                if (move_req) begin
                    if (legal) begin
                        fsm_d   = S_CHECK;
                        ack_d   = 1'b1;
                        pv_d    = 1'b1;
                        pc_d    = move_col;
                        pr_d    = col_height;
                        pp_d    = player_q;
                        ht_inc  = 1'b1;
                        count_d = move_count + 6'd1;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
`ifdef MOVE_TIMEOUT_EN
                // Idle turn expired: pass the move, timer restarts
                else if (timer_q == T_LAST) begin
                    player_d = ~player_q;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            S_CHECK: begin
                if (win_valid) begin
                    if (win_found) begin
                        fsm_d    = S_END;
                        status_d = player_q ? P2_WINS : P1_WINS;
                    end else if (move_count == 6'(MAX_MOVES)) begin
                        fsm_d    = S_END;
                        status_d = TIE;
                    end else begin
                        fsm_d    = S_TURN;
                        player_d = ~player_q;
                    end
                end
            end
            S_END: begin
                if (start) begin
                    fsm_d    = S_INIT;
                    count_d  = '0;
                    ht_clear = 1'b1;
                end
            end
            default: fsm_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= S_INIT;
            player_q <= PLAYER_1;
            status_q <= STILL_PLAYING;
        end else begin
            fsm_q    <= fsm_d;
            player_q <= player_d;
            status_q <= status_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= GAME_INIT;
            move_count   <= '0;
            place_valid  <= 1'b0;
            place_col    <= '0;
            place_row    <= '0;
            place_player <= 1'b0;
            move_ack     <= 1'b0;
            move_reject  <= 1'b0;
        end else begin
            state        <= state_code(fsm_d, player_d);
            move_count   <= count_d;
            place_valid  <= pv_d;
            place_col    <= pc_d;
            place_row    <= pr_d;
            place_player <= pp_d;
            move_ack     <= ack_d;
            move_reject  <= rej_d;
        end
    end

    assign game_status = status_q;

endmodule
